// File: rtl/forward_registered_burst.sv
// forward_registered_burst
// Forward-registered valid/ready slice that carries exactly DEPTH beats per
// burst. Data and valid toward the sink are registered. Ready toward the
// producer is combinational. A start pulse arms a burst. The final beat
// carries dst_last, and done pulses once the sink takes that beat.
// Optional feature macro: FWD_REG_STALL_CNT_EN adds the stall_cnt output,
// a saturating count of cycles in which the sink held back a pending beat.
module forward_registered_burst #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             start,
    input  logic             src_vaild,
    input  logic [WIDTH-1:0] src_data_in,
    output logic             src_ready,
    input  logic             dst_ready,
    output logic             dst_vaild,
    output logic [WIDTH-1:0] dst_data_out,
    output logic             dst_last,
    output logic             busy,
    output logic             done
`ifdef FWD_REG_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   beat_cnt;
    logic            accept;

    // Ready is live only in RUN, when the output register is empty or draining this cycle
    assign src_ready = (state == RUN) && (!dst_vaild || dst_ready);
    assign accept    = src_vaild && src_ready;

    // Burst FSM with the registered sink-side outputs
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            dst_vaild    <= 1'b0;
            dst_data_out <= '0;
            dst_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        dst_data_out <= src_data_in;
                        dst_vaild    <= 1'b1;
                        beat_cnt     <= beat_cnt + CW'(1);
                        if (beat_cnt == LAST_IDX) begin
                            dst_last <= 1'b1;
                            state    <= DRAIN;
                        end
                    end else if (dst_ready) begin
                        dst_vaild <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (dst_vaild && dst_ready) begin
                        dst_vaild <= 1'b0;
                        dst_last  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FWD_REG_STALL_CNT_EN
    // Saturating count of sink back-pressure cycles, restarted by each accepted start
    always_ff @(posedge clk) begin
        if (s_rst) begin
            stall_cnt <= 16'd0;
        end else if (state == IDLE && start) begin
            stall_cnt <= 16'd0;
        end else if (busy && dst_vaild && !dst_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_forward_registered_burst.sv
// tb_forward_registered_burst
// Directed bench for forward_registered_burst. One instance runs with DEPTH=4
// and one with DEPTH=1. They share every input except start.
// FWD_REG_STALL_CNT_EN enables the stall_cnt checks.
module tb_forward_registered_burst;

    logic       clk;
    logic       s_rst;
    logic       start4;
    logic       start1;
    logic       src_vaild;
    logic [7:0] src_data_in;
    logic       dst_ready;

    logic       d4_src_ready, d4_dst_vaild, d4_dst_last, d4_busy, d4_done;
    logic [7:0] d4_dst_data_out;
    logic       d1_src_ready, d1_dst_vaild, d1_dst_last, d1_busy, d1_done;
    logic [7:0] d1_dst_data_out;
`ifdef FWD_REG_STALL_CNT_EN
    logic [15:0] d4_stall_cnt;
    logic [15:0] d1_stall_cnt;
`endif

    int vectors;
    int miscompares;

    forward_registered_burst #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk          (clk),
        .s_rst        (s_rst),
        .start        (start4),
        .src_vaild    (src_vaild),
        .src_data_in  (src_data_in),
        .src_ready    (d4_src_ready),
        .dst_ready    (dst_ready),
        .dst_vaild    (d4_dst_vaild),
        .dst_data_out (d4_dst_data_out),
        .dst_last     (d4_dst_last),
        .busy         (d4_busy),
        .done         (d4_done)
`ifdef FWD_REG_STALL_CNT_EN
        ,
        .stall_cnt    (d4_stall_cnt)
`endif
    );

    forward_registered_burst #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk          (clk),
        .s_rst        (s_rst),
        .start        (start1),
        .src_vaild    (src_vaild),
        .src_data_in  (src_data_in),
        .src_ready    (d1_src_ready),
        .dst_ready    (dst_ready),
        .dst_vaild    (d1_dst_vaild),
        .dst_data_out (d1_dst_data_out),
        .dst_last     (d1_dst_last),
        .busy         (d1_busy),
        .done         (d1_done)
`ifdef FWD_REG_STALL_CNT_EN
        ,
        .stall_cnt    (d1_stall_cnt)
`endif
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Streams four beats (packed MSB-first) through dut4, starting in the first RUN cycle
    task automatic stream_four(input string tag, input logic [31:0] beats);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = beats[31 - 8*i -: 8];
            src_vaild   = 1'b1;
            src_data_in = b;
            dst_ready   = 1'b1;
            tick();
            check({tag, "_vld"},  32'(d4_dst_vaild), 32'd1);
            check({tag, "_data"}, 32'(d4_dst_data_out), 32'(b));
            check({tag, "_last"}, 32'(d4_dst_last), (i == 3) ? 32'd1 : 32'd0);
        end
        src_vaild = 1'b0;
        tick();
        check({tag, "_done"},    32'(d4_done), 32'd1);
        check({tag, "_busy0"},   32'(d4_busy), 32'd0);
        check({tag, "_vld0"},    32'(d4_dst_vaild), 32'd0);
        tick();
        check({tag, "_donepls"}, 32'(d4_done), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        s_rst       = 1'b1;
        start4      = 1'b0;
        start1      = 1'b0;
        src_vaild   = 1'b0;
        src_data_in = 8'h00;
        dst_ready   = 1'b0;

        // Reset values
        tick();
        tick();
        s_rst = 1'b0;
        #1;
        check("rst_vld",   32'(d4_dst_vaild), 32'd0);
        check("rst_data",  32'(d4_dst_data_out), 32'd0);
        check("rst_last",  32'(d4_dst_last), 32'd0);
        check("rst_busy",  32'(d4_busy), 32'd0);
        check("rst_done",  32'(d4_done), 32'd0);
        check("rst_rdy",   32'(d4_src_ready), 32'd0);

        // Basic burst 11,22,33,44 with the sink always ready
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("b1_busy",   32'(d4_busy), 32'd1);
        check("b1_vld0",   32'(d4_dst_vaild), 32'd0);
        #1;
        check("b1_rdy",    32'(d4_src_ready), 32'd1);
        stream_four("b1", 32'h11223344);

        // Sink stalls for three cycles after the first beat
        start4      = 1'b1;
        src_vaild   = 1'b1;
        src_data_in = 8'h11;
        dst_ready   = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        check("st_first",  32'(d4_dst_data_out), 32'h11);
        src_data_in = 8'h22;
        dst_ready   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_rdy0",  32'(d4_src_ready), 32'd0);
            check("st_vld",   32'(d4_dst_vaild), 32'd1);
            check("st_hold",  32'(d4_dst_data_out), 32'h11);
            tick();
        end
        check("st_hold3",  32'(d4_dst_data_out), 32'h11);
        dst_ready = 1'b1;
        #1;
        check("st_rdy1",   32'(d4_src_ready), 32'd1);
        tick();
        check("st_b2",     32'(d4_dst_data_out), 32'h22);
        src_data_in = 8'h33;
        tick();
        check("st_b3",     32'(d4_dst_data_out), 32'h33);
        check("st_b3last", 32'(d4_dst_last), 32'd0);
        src_data_in = 8'h44;
        tick();
        check("st_b4",     32'(d4_dst_data_out), 32'h44);
        check("st_b4last", 32'(d4_dst_last), 32'd1);
        src_vaild = 1'b0;
        #1;
        check("st_drainrdy", 32'(d4_src_ready), 32'd0);
        tick();
        check("st_done",   32'(d4_done), 32'd1);
`ifdef FWD_REG_STALL_CNT_EN
        check("st_stallcnt", 32'(d4_stall_cnt), 32'd3);
`endif
        tick();

        // Toggling producer valid, with start pulsed in RUN, DRAIN and the done cycle
        start4 = 1'b1;
        tick();
        start4      = 1'b0;
        src_vaild   = 1'b1;
        src_data_in = 8'hA1;
        tick();
        check("tg_a1",     32'(d4_dst_data_out), 32'hA1);
        check("tg_a1vld",  32'(d4_dst_vaild), 32'd1);
        src_vaild = 1'b0;
        tick();
        check("tg_gap1",   32'(d4_dst_vaild), 32'd0);
        start4      = 1'b1;
        src_vaild   = 1'b1;
        src_data_in = 8'hA2;
        tick();
        start4 = 1'b0;
        check("tg_a2",     32'(d4_dst_data_out), 32'hA2);
        src_vaild = 1'b0;
        tick();
        check("tg_gap2",   32'(d4_dst_vaild), 32'd0);
        src_vaild   = 1'b1;
        src_data_in = 8'hA3;
        tick();
        check("tg_a3",     32'(d4_dst_data_out), 32'hA3);
        check("tg_a3last", 32'(d4_dst_last), 32'd0);
        src_vaild = 1'b0;
        tick();
        check("tg_gap3",   32'(d4_dst_vaild), 32'd0);
        check("tg_nodone", 32'(d4_done), 32'd0);
        src_vaild   = 1'b1;
        src_data_in = 8'hA4;
        tick();
        check("tg_a4",     32'(d4_dst_data_out), 32'hA4);
        check("tg_a4last", 32'(d4_dst_last), 32'd1);
        src_vaild = 1'b0;
        start4    = 1'b1;
        tick();
        check("tg_done",   32'(d4_done), 32'd1);
        check("tg_busy0",  32'(d4_busy), 32'd0);
        tick();
        start4 = 1'b0;
        check("bb_busy",   32'(d4_busy), 32'd1);
        check("bb_done0",  32'(d4_done), 32'd0);
        stream_four("bb", 32'hB1B2B3B4);

        // DEPTH=1 single beat
        start1      = 1'b1;
        src_vaild   = 1'b1;
        src_data_in = 8'hA5;
        dst_ready   = 1'b1;
        tick();
        start1 = 1'b0;
        check("d1_busy",   32'(d1_busy), 32'd1);
        tick();
        src_vaild = 1'b0;
        check("d1_data",   32'(d1_dst_data_out), 32'hA5);
        check("d1_last",   32'(d1_dst_last), 32'd1);
        check("d1_vld",    32'(d1_dst_vaild), 32'd1);
        #1;
        check("d1_rdy0",   32'(d1_src_ready), 32'd0);
        tick();
        check("d1_done",   32'(d1_done), 32'd1);
        check("d1_vld0",   32'(d1_dst_vaild), 32'd0);
        tick();
        check("d1_donepls", 32'(d1_done), 32'd0);

        // Reset mid-burst with a beat held under back-pressure
        start4      = 1'b1;
        src_vaild   = 1'b1;
        src_data_in = 8'h11;
        dst_ready   = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        src_data_in = 8'h22;
        tick();
        check("mr_b2",     32'(d4_dst_data_out), 32'h22);
        dst_ready   = 1'b0;
        src_data_in = 8'h33;
        tick();
        check("mr_hold",   32'(d4_dst_data_out), 32'h22);
        s_rst = 1'b1;
        tick();
        s_rst     = 1'b0;
        dst_ready = 1'b1;
        src_vaild = 1'b0;
        #1;
        check("mr_vld",    32'(d4_dst_vaild), 32'd0);
        check("mr_data",   32'(d4_dst_data_out), 32'd0);
        check("mr_busy",   32'(d4_busy), 32'd0);
        check("mr_rdy",    32'(d4_src_ready), 32'd0);
`ifdef FWD_REG_STALL_CNT_EN
        check("mr_stall",  32'(d4_stall_cnt), 32'd0);
`endif
        tick();
        check("mr_nodone", 32'(d4_done), 32'd0);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("mr_busy1",  32'(d4_busy), 32'd1);
        stream_four("mr", 32'hC1C2C3C4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/forward_registered_burst.md
# forward_registered_burst

Forward-registered valid/ready pipeline stage that registers the data and valid path toward the sink and passes ready back combinationally. It is the complement of the backward-registered slice. It is burst-framed: a `start` pulse arms it to carry exactly DEPTH beats, flags the final beat with `dst_last`, and reports completion with a one-cycle `done` pulse. It sits between a stream producer and a sink whose input timing needs registered valid/data.

## Interface
- WIDTH, 8, data width in bits
- DEPTH, 256, beats per burst; legal range 1..65535; beat counter width is $clog2(DEPTH+1)
- clk  input  1  clock; all logic on rising edge
- s_rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle pulse arming a burst; honoured only in IDLE
- src_vaild  input  1  producer valid
- src_data_in  input  WIDTH  producer data
- src_ready  output  1  ready to producer; combinational
- dst_ready  input  1  sink ready
- dst_vaild  output  1  registered valid to sink
- dst_data_out  output  WIDTH  registered data to sink
- dst_last  output  1  registered; high with the final beat of the burst
- busy  output  1  registered; high in RUN or DRAIN
- done  output  1  registered one-cycle pulse after the final beat is taken
- stall_cnt  output  16  present only with FWD_REG_STALL_CNT_EN (see Configuration)

## Operation
- FSM states: IDLE, RUN, DRAIN.
- Reset: state IDLE. dst_vaild, dst_data_out, dst_last, busy, done and beat_cnt are all 0. src_ready is 0.
- IDLE:
  - src_ready=0.
  - start=1 -> RUN, beat_cnt<=0, busy<=1.
- RUN:
  - src_ready = !dst_vaild | dst_ready.
  - Accept = src_vaild & src_ready. On accept: dst_data_out<=src_data_in, dst_vaild<=1, beat_cnt<=beat_cnt+1.
  - On the accept where beat_cnt==DEPTH-1: dst_last<=1 and state -> DRAIN.
  - With no accept while dst_ready=1: dst_vaild<=0.
- DRAIN:
  - src_ready=0.
  - When dst_vaild & dst_ready: dst_vaild<=0, dst_last<=0, done<=1, busy<=0, state -> IDLE.
- start is ignored in RUN and DRAIN. A start in the same cycle that done is high is honoured, because state is already IDLE.
- dst_data_out and dst_last hold stable while dst_vaild & !dst_ready. The sink never sees data change under a pending valid.
- Protocol violation, not checked: src_vaild withdrawn without acceptance.
- DEPTH=1: the first accept sets dst_last and enters DRAIN directly.
- Reset asserted mid-burst: next cycle matches the reset values. Any in-flight beat is dropped and no done pulse is produced.

## Timing
- Latency: 1 cycle. A beat accepted at edge k is on dst at k+1.
- Throughput: 1 beat/cycle in RUN while dst_ready=1. Back-to-back accepts need no bubble.
- Backpressure: with dst_vaild=1 and dst_ready=0, src_ready falls in the same cycle (combinational path dst_ready -> src_ready).
- start at edge k: busy=1 and src_ready is live from cycle k+1.
- Final handshake at edge m: done=1 during cycle m+1 only, busy=0 from m+1. Minimum burst duration is DEPTH+1 cycles from RUN entry to done.

## Configuration
- FWD_REG_STALL_CNT_EN defined:
  - Adds a 16-bit output port stall_cnt.
  - Increments on each cycle with busy & dst_vaild & !dst_ready and saturates at 16'hFFFF.
  - Cleared to 0 on reset and on the start that enters RUN. Holds its value after done until the next start.
- Not defined: the stall_cnt port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then DEPTH=4, start pulse, src_vaild=1, data 8'h11,22,33,44, dst_ready=1 -> dst sees 11,22,33,44 on consecutive cycles starting 2 cycles after start, dst_last only with 44, done one cycle after 44 is taken, busy 0 thereafter.
- DEPTH=4, dst_ready held 0 for 3 cycles after the first beat -> dst_data_out stays 8'h11 with dst_vaild=1, src_ready=0 throughout, no beat lost or duplicated after release; with FWD_REG_STALL_CNT_EN, stall_cnt=3 at done.
- src_vaild toggling 1,0,1,0 with dst_ready=1 -> dst_vaild toggles with a 1-cycle lag, beat_cnt counts only accepts, dst_last on the 4th accepted beat.
- start pulsed during RUN and again during DRAIN -> ignored: exactly DEPTH beats and one done. A start in the done cycle launches the second burst with no gap.
- DEPTH=1, single beat 8'hA5 -> dst_last=1 with A5, RUN->DRAIN immediately, done one cycle after handshake.
- s_rst asserted after 2 of 4 beats, with a beat held under dst_ready=0 -> all outputs 0 next cycle, no done. A new start then delivers a full 4-beat burst.
